// File: rtl/etapa_decodificacion_pipe.sv
// ---------------------------------------------------------------------------
// etapa_decodificacion_pipe
//   MIPS decode stage with its ID/EX pipeline register folded in. It holds
//   the register file (with write-through bypass from WB), immediate
//   extension, destination select, ALU-control decode and load-use hazard
//   detection. Every ex_* output is registered; one cycle separates an
//   instruction on `instruccion` from its decoded form on ex_*.
//
// Parameters
//   ANCHO   datapath width (16..64); the immediate is extended to ANCHO.
//   NUM_REG register-file entries (power of two, 2..32). Addresses at or
//           above NUM_REG read 0 and ignore writes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instruccion, inst_valida   instruction from IF/ID and its valid flag
//   flush                      kill the instruction entering EX
//   reg_escribir, registro_escribir, dato_escribir   writeback from WB
//   destino_reg, alu_fuente, alu_op, mem_escribir, mem_leer, mem_a_reg,
//   ext_cero                   main-control signals for this instruction
//   stall                      combinational load-use stall request
//   ex_*                       registered ID/EX contents
//
// Flow control: IF/ID offers an instruction whenever inst_valida=1. It is
// consumed at the rising edge where inst_valida=1, flush=0 and stall=0.
// While stall=1 the upstream stage must hold PC and IF/ID so the same
// instruction is re-presented; flush overrides stall and drops it.
// ---------------------------------------------------------------------------
module etapa_decodificacion_pipe #(
  parameter int ANCHO   = 32,
  parameter int NUM_REG = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruccion,
  input  logic             inst_valida,
  input  logic             flush,
  input  logic             reg_escribir,
  input  logic [4:0]       registro_escribir,
  input  logic [ANCHO-1:0] dato_escribir,
  input  logic             destino_reg,
  input  logic             alu_fuente,
  input  logic [1:0]       alu_op,
  input  logic             mem_escribir,
  input  logic             mem_leer,
  input  logic             mem_a_reg,
  input  logic             ext_cero,
  output logic             stall,
  output logic             ex_valido,
  output logic [ANCHO-1:0] ex_dato1,
  output logic [ANCHO-1:0] ex_dato2,
  output logic [ANCHO-1:0] ex_operando_b,
  output logic [ANCHO-1:0] ex_inmediato,
  output logic [3:0]       ex_func_alu,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_dest,
  output logic             ex_reg_escribir,
  output logic             ex_mem_escribir,
  output logic             ex_mem_leer,
  output logic             ex_mem_a_reg
);

  localparam int AW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [5:0] LIMITE = 6'(NUM_REG);

  // Instruction fields
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [5:0]  w_funct;
  logic        w_unused_campos;

  assign w_rs    = instruccion[25:21];
  assign w_rt    = instruccion[20:16];
  assign w_rd    = instruccion[15:11];
  assign w_imm   = instruccion[15:0];
  assign w_funct = instruccion[5:0];
  // Opcode and shamt are decoded upstream / in EX, not here.
  assign w_unused_campos = ^{instruccion[31:26], instruccion[10:6]};

  // Register file
  logic [ANCHO-1:0] r_banco [NUM_REG];
  logic             w_wr_ok, w_rs_ok, w_rt_ok;
  logic [ANCHO-1:0] w_dato1, w_dato2;

  assign w_wr_ok = reg_escribir && (registro_escribir != 5'd0) &&
                   ({1'b0, registro_escribir} < LIMITE);
  assign w_rs_ok = (w_rs != 5'd0) && ({1'b0, w_rs} < LIMITE);
  assign w_rt_ok = (w_rt != 5'd0) && ({1'b0, w_rt} < LIMITE);

  // Reads see a same-cycle writeback so WB->ID needs no stall.
  always_comb begin
    w_dato1 = '0;
    w_dato2 = '0;
    if (w_rs_ok)
      w_dato1 = (w_wr_ok && registro_escribir == w_rs) ? dato_escribir
                                                       : r_banco[w_rs[AW-1:0]];
    if (w_rt_ok)
      w_dato2 = (w_wr_ok && registro_escribir == w_rt) ? dato_escribir
                                                       : r_banco[w_rt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) r_banco[i] <= '0;
    end else if (w_wr_ok) begin
      r_banco[registro_escribir[AW-1:0]] <= dato_escribir;
    end
  end

  // Immediate extension and operand-B mux
  logic [ANCHO-1:0] w_inmediato, w_operando_b;

  assign w_inmediato  = ext_cero ? ANCHO'(w_imm) : ANCHO'($signed(w_imm));
  assign w_operando_b = alu_fuente ? w_inmediato : w_dato2;

  // ALU control
  logic [3:0] w_func_alu;

  always_comb begin
    w_func_alu = 4'b1111;
    case (alu_op)
      2'b00: w_func_alu = 4'b0010;
      2'b01: w_func_alu = 4'b0110;
      2'b11: w_func_alu = 4'b0001;
      default: begin
        case (w_funct)
          6'b100000: w_func_alu = 4'b0010;
          6'b100010: w_func_alu = 4'b0110;
          6'b100100: w_func_alu = 4'b0000;
          6'b100101: w_func_alu = 4'b0001;
          6'b101010: w_func_alu = 4'b0111;
          default:   w_func_alu = 4'b1111;
        endcase
      end
    endcase
  end

  // Destination and write-enable
  logic [4:0] w_dest;
  logic       w_reg_escribir;

  assign w_dest         = destino_reg ? w_rd : w_rt;
  assign w_reg_escribir = !mem_escribir && (destino_reg || mem_leer || alu_fuente);

  // Load-use hazard: rt counts as a source only for R-type and stores.
  logic w_usa_rt, w_riesgo, w_burbuja;

  assign w_usa_rt  = destino_reg || mem_escribir;
  assign w_riesgo  = ex_valido && ex_mem_leer && (ex_dest != 5'd0) &&
                     inst_valida && !flush &&
                     ((ex_dest == w_rs) || (w_usa_rt && ex_dest == w_rt));
  assign stall     = w_riesgo;
  assign w_burbuja = flush || w_riesgo || !inst_valida;

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_burbuja) begin
      ex_valido       <= 1'b0;
      ex_dato1        <= '0;
      ex_dato2        <= '0;
      ex_operando_b   <= '0;
      ex_inmediato    <= '0;
      ex_func_alu     <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_dest         <= '0;
      ex_reg_escribir <= 1'b0;
      ex_mem_escribir <= 1'b0;
      ex_mem_leer     <= 1'b0;
      ex_mem_a_reg    <= 1'b0;
    end else begin
      ex_valido       <= 1'b1;
      ex_dato1        <= w_dato1;
      ex_dato2        <= w_dato2;
      ex_operando_b   <= w_operando_b;
      ex_inmediato    <= w_inmediato;
      ex_func_alu     <= w_func_alu;
      ex_rs           <= w_rs;
      ex_rt           <= w_rt;
      ex_dest         <= w_dest;
      ex_reg_escribir <= w_reg_escribir;
      ex_mem_escribir <= mem_escribir;
      ex_mem_leer     <= mem_leer;
      ex_mem_a_reg    <= mem_a_reg;
    end
  end

endmodule

// File: tb/tb_etapa_decodificacion_pipe.sv
// ---------------------------------------------------------------------------
// Directed testbench for etapa_decodificacion_pipe. Two instances share the
// stimulus: dut (ANCHO=32, NUM_REG=32) and dut16 (ANCHO=16, NUM_REG=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// there too, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_etapa_decodificacion_pipe;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus
  logic [31:0] instruccion;
  logic        inst_valida, flush, reg_escribir;
  logic [4:0]  registro_escribir;
  logic [31:0] dato_escribir;
  logic [15:0] dato16;
  logic        destino_reg, alu_fuente, mem_escribir, mem_leer, mem_a_reg, ext_cero;
  logic [1:0]  alu_op;

  assign dato16 = dato_escribir[15:0];

  // 32-bit instance outputs
  logic        stall, ex_valido, ex_reg_escribir, ex_mem_escribir, ex_mem_leer, ex_mem_a_reg;
  logic [31:0] ex_dato1, ex_dato2, ex_operando_b, ex_inmediato;
  logic [3:0]  ex_func_alu;
  logic [4:0]  ex_rs, ex_rt, ex_dest;

  // 16-bit instance outputs
  logic        s16_stall, s16_valido, s16_reg_escribir, s16_mem_escribir, s16_mem_leer, s16_mem_a_reg;
  logic [15:0] s16_dato1, s16_dato2, s16_operando_b, s16_inmediato;
  logic [3:0]  s16_func_alu;
  logic [4:0]  s16_rs, s16_rt, s16_dest;

  etapa_decodificacion_pipe #(.ANCHO(32), .NUM_REG(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .inst_valida(inst_valida),
    .flush(flush), .reg_escribir(reg_escribir), .registro_escribir(registro_escribir),
    .dato_escribir(dato_escribir), .destino_reg(destino_reg), .alu_fuente(alu_fuente),
    .alu_op(alu_op), .mem_escribir(mem_escribir), .mem_leer(mem_leer),
    .mem_a_reg(mem_a_reg), .ext_cero(ext_cero), .stall(stall), .ex_valido(ex_valido),
    .ex_dato1(ex_dato1), .ex_dato2(ex_dato2), .ex_operando_b(ex_operando_b),
    .ex_inmediato(ex_inmediato), .ex_func_alu(ex_func_alu), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_escribir(ex_reg_escribir),
    .ex_mem_escribir(ex_mem_escribir), .ex_mem_leer(ex_mem_leer),
    .ex_mem_a_reg(ex_mem_a_reg)
  );

  etapa_decodificacion_pipe #(.ANCHO(16), .NUM_REG(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion), .inst_valida(inst_valida),
    .flush(flush), .reg_escribir(reg_escribir), .registro_escribir(registro_escribir),
    .dato_escribir(dato16), .destino_reg(destino_reg), .alu_fuente(alu_fuente),
    .alu_op(alu_op), .mem_escribir(mem_escribir), .mem_leer(mem_leer),
    .mem_a_reg(mem_a_reg), .ext_cero(ext_cero), .stall(s16_stall), .ex_valido(s16_valido),
    .ex_dato1(s16_dato1), .ex_dato2(s16_dato2), .ex_operando_b(s16_operando_b),
    .ex_inmediato(s16_inmediato), .ex_func_alu(s16_func_alu), .ex_rs(s16_rs),
    .ex_rt(s16_rt), .ex_dest(s16_dest), .ex_reg_escribir(s16_reg_escribir),
    .ex_mem_escribir(s16_mem_escribir), .ex_mem_leer(s16_mem_leer),
    .ex_mem_a_reg(s16_mem_a_reg)
  );

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ctrl: destino_reg, alu_fuente, alu_op, mem_escribir, mem_leer, mem_a_reg, ext_cero
  task automatic set_ctrl(input logic dr, af, input logic [1:0] op,
                          input logic mw, mr, mar, ec);
    destino_reg = dr; alu_fuente = af; alu_op = op;
    mem_escribir = mw; mem_leer = mr; mem_a_reg = mar; ext_cero = ec;
  endtask

  task automatic ctrl_rtype();  set_ctrl(1, 0, 2'b10, 0, 0, 0, 0); endtask
  task automatic ctrl_lw();     set_ctrl(0, 1, 2'b00, 0, 1, 1, 0); endtask
  task automatic ctrl_sw();     set_ctrl(0, 1, 2'b00, 1, 0, 0, 0); endtask
  task automatic ctrl_addi();   set_ctrl(0, 1, 2'b00, 0, 0, 0, 0); endtask

  task automatic present(input logic [31:0] ins);
    instruccion = ins; inst_valida = 1'b1;
  endtask

  task automatic idle();
    inst_valida = 1'b0; flush = 1'b0; instruccion = '0;
    set_ctrl(0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    idle();
    reg_escribir = 1'b1; registro_escribir = a; dato_escribir = d;
    tick();
    reg_escribir = 1'b0; registro_escribir = '0; dato_escribir = '0;
  endtask

  // Tests
  task automatic test_reset();
    idle(); reg_escribir = 0; registro_escribir = '0; dato_escribir = '0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (ex_valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", ex_valido); end
    checks++; if ({ex_dato1, ex_dato2, ex_operando_b, ex_inmediato} !== 128'd0) begin errors++; $display("FAIL reset_datos: got %h expected 0", {ex_dato1, ex_dato2, ex_operando_b, ex_inmediato}); end
    checks++; if ({ex_func_alu, ex_rs, ex_rt, ex_dest, ex_reg_escribir, ex_mem_escribir, ex_mem_leer, ex_mem_a_reg} !== 23'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", {ex_func_alu, ex_rs, ex_rt, ex_dest, ex_reg_escribir, ex_mem_escribir, ex_mem_leer, ex_mem_a_reg}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'h0000_00AA);
    ctrl_rtype(); present(r_type(5, 5, 3, 6'b100000));
    tick();
    checks++; if (ex_dato1 !== 32'hAA) begin errors++; $display("FAIL add_dato1: got %h expected 000000aa", ex_dato1); end
    checks++; if (ex_dato2 !== 32'hAA) begin errors++; $display("FAIL add_dato2: got %h expected 000000aa", ex_dato2); end
    checks++; if (ex_operando_b !== 32'hAA) begin errors++; $display("FAIL add_opb: got %h expected 000000aa", ex_operando_b); end
    checks++; if (ex_func_alu !== 4'b0010) begin errors++; $display("FAIL add_func: got %b expected 0010", ex_func_alu); end
    checks++; if ({ex_valido, ex_dest, ex_rs, ex_rt, ex_reg_escribir} !== {1'b1, 5'd3, 5'd5, 5'd5, 1'b1}) begin errors++; $display("FAIL add_campos: got %h expected %h", {ex_valido, ex_dest, ex_rs, ex_rt, ex_reg_escribir}, {1'b1, 5'd3, 5'd5, 5'd5, 1'b1}); end
    idle(); tick();
  endtask

  task automatic test_bypass_r0();
    // Write r7 in the same cycle the reader decodes
    ctrl_rtype(); present(r_type(7, 0, 1, 6'b100000));
    reg_escribir = 1; registro_escribir = 5'd7; dato_escribir = 32'h1234;
    tick();
    reg_escribir = 0; registro_escribir = '0; dato_escribir = '0;
    checks++; if (ex_dato1 !== 32'h1234) begin errors++; $display("FAIL bypass_rs: got %h expected 00001234", ex_dato1); end
    checks++; if (ex_dato2 !== 32'h0) begin errors++; $display("FAIL bypass_rt0: got %h expected 0", ex_dato2); end
    // r7 must also have been stored
    present(r_type(0, 7, 1, 6'b100000));
    tick();
    checks++; if (ex_dato2 !== 32'h1234) begin errors++; $display("FAIL r7_stored: got %h expected 00001234", ex_dato2); end
    write_reg(5'd0, 32'h0000_FFFF);
    ctrl_rtype(); present(r_type(0, 0, 1, 6'b100000));
    tick();
    checks++; if ({ex_dato1, ex_dato2} !== 64'd0) begin errors++; $display("FAIL r0_read: got %h expected 0", {ex_dato1, ex_dato2}); end
    // Bypass must not apply to r0 either
    present(r_type(0, 0, 1, 6'b100000));
    reg_escribir = 1; registro_escribir = 5'd0; dato_escribir = 32'hDEAD_BEEF;
    tick();
    reg_escribir = 0; dato_escribir = '0;
    checks++; if (ex_dato1 !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", ex_dato1); end
    idle(); tick();
  endtask

  task automatic test_extension();
    set_ctrl(0, 1, 2'b00, 0, 0, 0, 0); present(i_type(6'b001000, 0, 2, 16'h8001));
    tick();
    checks++; if (ex_operando_b !== 32'hFFFF_8001) begin errors++; $display("FAIL sext_opb: got %h expected ffff8001", ex_operando_b); end
    checks++; if (ex_inmediato !== 32'hFFFF_8001) begin errors++; $display("FAIL sext_imm: got %h expected ffff8001", ex_inmediato); end
    checks++; if ({ex_dest, ex_reg_escribir, ex_func_alu} !== {5'd2, 1'b1, 4'b0010}) begin errors++; $display("FAIL addi_ctrl: got %h expected %h", {ex_dest, ex_reg_escribir, ex_func_alu}, {5'd2, 1'b1, 4'b0010}); end
    ext_cero = 1'b1;
    tick();
    checks++; if (ex_operando_b !== 32'h0000_8001) begin errors++; $display("FAIL zext_opb: got %h expected 00008001", ex_operando_b); end
    idle(); tick();
  endtask

  task automatic test_alu_ctrl();
    logic [1:0] ops  [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns  [9] = '{6'b100010, 6'b100000, 6'b100000, 6'b100000, 6'b100010,
                             6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [3:0] exps [9] = '{4'b0010, 4'b0110, 4'b0001, 4'b0010, 4'b0110,
                             4'b0000, 4'b0001, 4'b0111, 4'b1111};
    for (int i = 0; i < 9; i++) begin
      ctrl_rtype(); alu_op = ops[i];
      present(r_type(1, 2, 3, fns[i]));
      tick();
      checks++; if (ex_func_alu !== exps[i]) begin errors++; $display("FAIL alu_ctrl[%0d]: got %b expected %b", i, ex_func_alu, exps[i]); end
    end
    idle(); tick();
  endtask

  task automatic test_load_use();
    // lw r4 then add r2,r4,r1
    ctrl_lw(); present(i_type(6'b100011, 0, 4, 16'h0000));
    tick();
    checks++; if ({ex_valido, ex_mem_leer, ex_mem_a_reg, ex_reg_escribir, ex_dest} !== {4'b1111, 5'd4}) begin errors++; $display("FAIL lw_ex: got %h expected %h", {ex_valido, ex_mem_leer, ex_mem_a_reg, ex_reg_escribir, ex_dest}, {4'b1111, 5'd4}); end
    ctrl_rtype(); present(r_type(4, 1, 2, 6'b100000));
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall); end
    tick();
    checks++; if ({ex_valido, ex_reg_escribir, ex_mem_leer} !== 3'b000) begin errors++; $display("FAIL lu_bubble: got %b expected 000", {ex_valido, ex_reg_escribir, ex_mem_leer}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b expected 0", stall); end
    tick();
    checks++; if ({ex_valido, ex_rs, ex_dest} !== {1'b1, 5'd4, 5'd2}) begin errors++; $display("FAIL lu_add_loaded: got %h expected %h", {ex_valido, ex_rs, ex_dest}, {1'b1, 5'd4, 5'd2}); end
    // lw r4 then sw r4,0(r9): rt is a source for stores
    ctrl_lw(); present(i_type(6'b100011, 0, 4, 16'h0000));
    tick();
    ctrl_sw(); present(i_type(6'b101011, 9, 4, 16'h0000));
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall: got %b expected 1", stall); end
    tick(); tick();
    checks++; if ({ex_valido, ex_mem_escribir, ex_reg_escribir, ex_rt} !== {1'b1, 1'b1, 1'b0, 5'd4}) begin errors++; $display("FAIL sw_loaded: got %h expected %h", {ex_valido, ex_mem_escribir, ex_reg_escribir, ex_rt}, {1'b1, 1'b1, 1'b0, 5'd4}); end
    // lw r4 then addi r2,r9,1 and addi r4,r9,1: no stall (rt is not a source)
    ctrl_lw(); present(i_type(6'b100011, 0, 4, 16'h0000));
    tick();
    ctrl_addi(); present(i_type(6'b001000, 9, 2, 16'h0001));
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addi_nostall: got %b expected 0", stall); end
    present(i_type(6'b001000, 9, 4, 16'h0001));
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addi_rt_nostall: got %b expected 0", stall); end
    tick();
    checks++; if ({ex_valido, ex_dest, ex_operando_b} !== {1'b1, 5'd4, 32'd1}) begin errors++; $display("FAIL addi_loaded: got %h expected %h", {ex_valido, ex_dest, ex_operando_b}, {1'b1, 5'd4, 32'd1}); end
    idle(); tick();
  endtask

  task automatic test_flush_stall();
    ctrl_lw(); present(i_type(6'b100011, 0, 4, 16'h0000));
    tick();
    ctrl_rtype(); present(r_type(4, 1, 2, 6'b100000)); flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tick();
    checks++; if ({ex_valido, ex_reg_escribir, ex_dest} !== 7'd0) begin errors++; $display("FAIL flush_bubble: got %h expected 0", {ex_valido, ex_reg_escribir, ex_dest}); end
    flush = 1'b0;
    tick();
    checks++; if ({ex_valido, ex_rs} !== {1'b1, 5'd4}) begin errors++; $display("FAIL after_flush: got %h expected %h", {ex_valido, ex_rs}, {1'b1, 5'd4}); end
    inst_valida = 1'b0;
    tick();
    checks++; if (ex_valido !== 1'b0) begin errors++; $display("FAIL invalid_bubble: got %b expected 0", ex_valido); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_stall();
    write_reg(5'd6, 32'h0000_0077);
    ctrl_lw(); present(i_type(6'b100011, 0, 4, 16'h0000));
    tick();
    ctrl_rtype(); present(r_type(4, 6, 2, 6'b100000));
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b expected 1", stall); end
    rst_n = 1'b0;
    #1;
    checks++; if ({stall, ex_valido, ex_mem_leer, ex_dest} !== 8'd0) begin errors++; $display("FAIL mid_stall_reset: got %h expected 0", {stall, ex_valido, ex_mem_leer, ex_dest}); end
    rst_n = 1'b1;
    tick();
    checks++; if ({ex_valido, ex_rs, ex_dest} !== {1'b1, 5'd4, 5'd2}) begin errors++; $display("FAIL post_reset_load: got %h expected %h", {ex_valido, ex_rs, ex_dest}, {1'b1, 5'd4, 5'd2}); end
    checks++; if (ex_dato2 !== 32'd0) begin errors++; $display("FAIL regfile_cleared: got %h expected 0", ex_dato2); end
    idle(); tick();
  endtask

  task automatic test_param16();
    write_reg(5'd1, 32'h0000_0011);
    write_reg(5'd3, 32'h0000_1234);
    // Write r9 while decoding rs=9: out of range, no store and no bypass
    ctrl_rtype(); present(r_type(9, 3, 2, 6'b100000));
    reg_escribir = 1; registro_escribir = 5'd9; dato_escribir = 32'h0000_55AA;
    tick();
    reg_escribir = 0; registro_escribir = '0; dato_escribir = '0;
    checks++; if (s16_dato1 !== 16'h0) begin errors++; $display("FAIL p16_r9_bypass: got %h expected 0", s16_dato1); end
    checks++; if (s16_dato2 !== 16'h1234) begin errors++; $display("FAIL p16_r3: got %h expected 1234", s16_dato2); end
    present(r_type(9, 1, 2, 6'b100000));
    tick();
    checks++; if (s16_dato1 !== 16'h0) begin errors++; $display("FAIL p16_r9_read: got %h expected 0", s16_dato1); end
    checks++; if (s16_dato2 !== 16'h0011) begin errors++; $display("FAIL p16_r1_alias: got %h expected 0011", s16_dato2); end
    checks++; if (ex_dato1 !== 32'h55AA) begin errors++; $display("FAIL p32_r9: got %h expected 000055aa", ex_dato1); end
    set_ctrl(0, 1, 2'b00, 0, 0, 0, 0); present(i_type(6'b001000, 0, 2, 16'h8000));
    tick();
    checks++; if (s16_inmediato !== 16'h8000 || s16_operando_b !== 16'h8000) begin errors++; $display("FAIL p16_sext: got %h/%h expected 8000", s16_inmediato, s16_operando_b); end
    checks++; if (ex_inmediato !== 32'hFFFF_8000) begin errors++; $display("FAIL p32_sext: got %h expected ffff8000", ex_inmediato); end
    idle(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle(); reg_escribir = 0; registro_escribir = '0; dato_escribir = '0;
    test_reset();
    test_write_read();
    test_bypass_r0();
    test_extension();
    test_alu_ctrl();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_param16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/etapa_decodificacion_pipe.md
Name: etapa_decodificacion_pipe

Overview:
Parametrised MIPS decode stage with an integrated ID/EX pipeline register. It contains the register file (with write-through bypass), sign/zero immediate extension, destination-register select, ALU-control decode and load-use hazard detection. It sits between the IF/ID register and the execute stage. It adds registered outputs, bubble insertion, flush and a stall request.

Parameters:
ANCHO, 32, datapath/register width in bits (16..64); immediate extended to ANCHO.
NUM_REG, 32, register-file entries (power of two, 2..32); addresses at or above NUM_REG read 0 and ignore writes.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
instruccion  in  32  instruction from IF/ID.
inst_valida  in  1  instruccion holds a valid instruction.
flush  in  1  kill the instruction entering EX (branch/jump taken).
reg_escribir  in  1  writeback enable from WB.
registro_escribir  in  5  writeback address.
dato_escribir  in  ANCHO  writeback data.
destino_reg  in  1  1=rd, 0=rt as destination; also marks rt as a source.
alu_fuente  in  1  1=immediate, 0=rt as ALU operand B.
alu_op  in  2  main-control ALU class.
mem_escribir, mem_leer, mem_a_reg  in  1 each  memory controls.
ext_cero  in  1  1=zero-extend imm[15:0], 0=sign-extend.
stall  out  1  combinational load-use stall; upstream holds PC and IF/ID.
ex_valido  out  1  EX slot holds a real instruction.
ex_dato1, ex_dato2  out  ANCHO  rs value and raw rt value (store data).
ex_operando_b  out  ANCHO  ALU operand B after alu_fuente mux.
ex_inmediato  out  ANCHO  extended immediate.
ex_func_alu  out  4  ALU function code.
ex_rs, ex_rt, ex_dest  out  5 each  source and destination register numbers.
ex_reg_escribir, ex_mem_escribir, ex_mem_leer, ex_mem_a_reg  out  1 each  registered controls.

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0 and all register-file entries 0, immediately, irrespective of clk. stall=0 while in reset.
- Register file:
  - Write on rising clk when reg_escribir=1 and 0 < registro_escribir < NUM_REG.
  - Register 0 always reads 0.
  - Reads are combinational. If the read address equals registro_escribir with a valid write pending this cycle (address nonzero), the read returns dato_escribir (bypass).
- Extension: ext_cero=0 replicates bit 15 to ANCHO; ext_cero=1 pads with zeros.
- ALU control (ex_func_alu):
  - alu_op=00 -> 0010 (add).
  - alu_op=01 -> 0110 (sub).
  - alu_op=11 -> 0001 (or).
  - alu_op=10 decodes funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111; any other funct -> 1111.
- Destination: ex_dest = instruccion[15:11] if destino_reg=1, else [20:16].
- ex_reg_escribir is derived as: not mem_escribir AND (destino_reg OR mem_leer OR alu_fuente); a bubble forces it to 0.
- Hazard, combinational: stall=1 when all of the following hold:
  - ex_valido=1, ex_mem_leer=1 and ex_dest != 0;
  - inst_valida=1 and flush=0;
  - either ex_dest == rs, or ex_dest == rt with (destino_reg=1 or mem_escribir=1).
- Next-state priority at rising clk, highest first:
  1. flush=1 -> bubble.
  2. stall=1 -> bubble.
  3. inst_valida=0 -> bubble.
  4. Otherwise load the decoded instruction and set ex_valido=1.
- Bubble: every ex_* output is 0, including ex_valido and all controls.
- Latency: one cycle from instruccion to ex_* outputs. During a stall the upstream instruction is re-presented and loads once the hazard clears (exactly one bubble per load-use).
- A writeback coincident with decode of the reader is visible via bypass in the same cycle; no extra stall.
- Reset mid-stall clears stall and all ex_* immediately. After release the first instruction loads with no residual bubble.

Test Plan:
1. Reset then write: rst_n low for 2 cycles -> all ex_* = 0. Write r5=0x0000_00AA, then decode add r3,r5,r5 (alu_op=10, funct 100000) -> next cycle ex_dato1=ex_dato2=0xAA, ex_func_alu=0010, ex_dest=3, ex_valido=1.
2. Bypass and r0: write r7=0x1234 in the same cycle as decoding an instruction that reads rs=7 -> ex_dato1=0x1234. A write to r0 of 0xFFFF, then a read of r0 -> 0.
3. Extension: imm=0x8001 with alu_fuente=1 -> ext_cero=0 gives ex_operando_b=0xFFFF_8001; ext_cero=1 gives 0x0000_8001.
4. Load-use: lw r4 followed by add r2,r4,r1 -> stall=1 for exactly one cycle, one bubble (ex_valido=0), then the add loads with ex_rs=4. The same sequence using sw that reads rt=4 also stalls; addi r2,r9,1 does not.
5. Flush vs stall: assert flush in the stall cycle of scenario 4 -> stall=0, bubble next cycle; unknown funct 000111 with alu_op=10 -> ex_func_alu=1111.
6. Parametrisation: ANCHO=16, NUM_REG=8 -> write to r9 is ignored and reads of r9 return 0; imm 0x8000 sign-extends to 0x8000.
